shifter_operand_pipe: RTL and testbench
=======================================

// Module: shifter_operand_pipe
// PURPOSE
//  Two-stage elastic pipeline that produces the data-processing shifter operand and the shifter carry-out.
//  Selects the shiftee source: sign/zero-extended imm8, Rm, imm32 or rotated imm8.
//  Applies LSL/LSR/ASR/ROR/RRX with immediate-specified or register-specified (Rs[7:0]) amount.
//  Sits between register-read and the ALU, and replaces the combinational source-select stage.
// PARAMETERS
//  DATA_W         32  operand width; power of two, >= 16
//  TAG_W          4   width of the sideband tag carried alongside each operand
//  IMM8_SIGN_EXT  1   1: src 00 sign-extends imm8; 0: src 00 zero-extends it
// PORTS
//  clk             in   1        clock, rising edge
//  rst_n           in   1        asynchronous reset, active low
//  flush           in   1        synchronous pipeline kill
//  in_valid        in   1        request valid
//  in_ready        out  1        request accepted when in_valid && in_ready
//  in_src_sel      in   2        00 ext(imm8), 01 Rm, 10 imm32, 11 imm8 ROR 2*rot
//  in_imm8         in   8        8-bit immediate
//  in_rot          in   4        rotate field for src 11
//  in_imm32        in   DATA_W   wide immediate
//  in_rm           in   DATA_W   Rm value
//  in_rs           in   8        Rs[7:0], used when in_shift_by_reg=1
//  in_shift_type   in   2        00 LSL, 01 LSR, 10 ASR, 11 ROR
//  in_shift_imm    in   log2(W)  immediate shift amount
//  in_shift_by_reg in   1        1: amount = in_rs; 0: amount = in_shift_imm
//  in_carry        in   1        current C flag
//  in_tag          in   TAG_W    sideband tag, passed through unchanged
//  out_valid       out  1        result valid
//  out_ready       in   1        consumer accepts when out_valid && out_ready
//  out_operand     out  DATA_W   shifter operand
//  out_carry       out  1        shifter carry-out
//  out_tag         out  TAG_W    tag of this result
// BEHAVIOUR
//  Reset (async, rst_n=0): all valid bits 0; out_operand, out_carry and out_tag are 0; in_ready=1.
//  Latency: 2 cycles from acceptance to out_valid. Throughput: 1 per cycle with no bubbles.
//  Stage 1 registers the selected shiftee, the carry-in, the tag and a normalised op (type plus amount class).
//  Stage 2 registers the result. adv2 = !v2 | out_ready; in_ready = !v1 | adv2.
//  Output holds stable while out_valid && !out_ready. No combinational path from out_ready to out data.
//  flush=1: v1 and v2 clear at the next edge. A request accepted in the same cycle is dropped.
//  src 11: value = zext(imm8) ROR 2*rot; the shift fields are ignored.
//    src 11 carry = (rot==0) ? in_carry : value[W-1].
//  Immediate amount n (src 00/01/10, shift_by_reg=0):
//    LSL #0 -> value unchanged, carry = in_carry.
//    LSR #0 = LSR #W; ASR #0 = ASR #W.
//    ROR #0 = RRX: result {in_carry, v[W-1:1]}, carry v[0].
//  Register amount a = Rs[7:0]:
//    a==0 -> value unchanged, carry = in_carry (all types).
//    LSL: a<W -> carry v[W-a]; a==W -> result 0, carry v[0]; a>W -> result 0, carry 0.
//    LSR: a<W -> carry v[a-1]; a==W -> result 0, carry v[W-1]; a>W -> result 0, carry 0.
//    ASR: a>=W -> every result bit = v[W-1], carry v[W-1].
//    ROR: (a mod W)==0 -> value unchanged, carry v[W-1]; else rotate by a mod W, carry result[W-1].
//  Flush wins over acceptance when both occur in a cycle. Reset mid-stream discards all in-flight data.
// STRUCTURE
//  Package shifter_pkg holds:
//    SRC_* encodings, SHIFT_LSL/LSR/ASR/ROR, and the normalised-op enum (PASS, LSL, LSR, ASR, ROR, RRX, ZERO, FILL).
//    The function clog2 for amount width.
//  Sub-module shift_core: combinational; (value, op, amt, cin) -> (result, cout); instantiated in stage 2.
//  The valid/ready pipeline control lives in the top-level module.
// TESTING
//  1 src00, imm8=0x80, IMM8_SIGN_EXT=1, LSL #0, cin=1 -> 0xFFFFFF80, carry 1, 2 cycles after accept.
//  2 src11, imm8=0xFF, rot=4 (ROR 8), cin=0 -> 0xFF000000, carry 1. With rot=0 -> 0x000000FF, carry = cin.
//  3 Rm=0x80000001, reg amounts: LSL 32 -> 0,c1; LSR 33 -> 0,c0; ASR 40 -> 0xFFFFFFFF,c1; ROR 64 -> unchanged,c1.
//  4 Rm=0x00000003, imm ROR #0 (RRX), cin=1 -> 0x80000001, carry 1. Imm LSR #0 -> 0, carry 0.
//  5 Back-to-back stream of 8 tags 0..7:
//    Hold out_ready=0 for 3 cycles -> in_ready drops after 2 accepts; no loss, no duplicates; tags arrive in order.
//  6 Assert flush with v1=v2=1 and in_valid=1 -> next cycle out_valid=0, and the flushed tags never appear.
//    rst_n pulsed mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared encodings and helpers for the shifter operand pipeline.
package shifter_pkg;

  localparam logic [1:0] SRC_EXT_IMM8 = 2'b00;
  localparam logic [1:0] SRC_RM       = 2'b01;
  localparam logic [1:0] SRC_IMM32    = 2'b10;
  localparam logic [1:0] SRC_ROT_IMM8 = 2'b11;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  // Edge cases of the encoded shift are folded away in stage 1, so the
  // shift core only ever sees in-range amounts (1..W-1) for LSL/LSR/ASR/ROR.
  typedef enum logic [2:0] {
    OP_PASS, OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX, OP_ZERO, OP_FILL
  } shop_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/shifter_operand_pipe_shift_core.sv
// Combinational barrel shifter on a normalised op; zero latency, no flow control.
// ZERO/PASS take their carry from i_cin, which stage 1 pre-computes for those cases.
module shift_core
  import shifter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] i_value,
  input  shop_e             i_op,
  input  logic [AMT_W-1:0]  i_amt,
  input  logic              i_cin,
  output logic [DATA_W-1:0] o_result,
  output logic              o_cout
);

  logic [DATA_W:0]   w_lsl_ext;
  logic [DATA_W:0]   w_lsr_ext;
  logic [DATA_W:0]   w_asr_ext;
  logic [AMT_W-1:0]  w_rol_amt;
  logic [DATA_W-1:0] w_ror;

  // One guard bit beyond the data catches the last bit shifted out.
  assign w_lsl_ext = {1'b0, i_value} << i_amt;
  assign w_lsr_ext = {i_value, 1'b0} >> i_amt;
  assign w_asr_ext = $signed({i_value, 1'b0}) >>> i_amt;
  assign w_rol_amt = AMT_W'(0) - i_amt;
  assign w_ror     = (i_value >> i_amt) | (i_value << w_rol_amt);

  always_comb begin
    o_result = i_value;
    o_cout   = i_cin;
    case (i_op)
      OP_LSL:  begin o_result = w_lsl_ext[DATA_W-1:0]; o_cout = w_lsl_ext[DATA_W]; end
      OP_LSR:  begin o_result = w_lsr_ext[DATA_W:1];   o_cout = w_lsr_ext[0];      end
      OP_ASR:  begin o_result = w_asr_ext[DATA_W:1];   o_cout = w_asr_ext[0];      end
      OP_ROR:  begin o_result = w_ror;                 o_cout = w_ror[DATA_W-1];   end
      OP_RRX:  begin o_result = {i_cin, i_value[DATA_W-1:1]}; o_cout = i_value[0]; end
      OP_ZERO: begin o_result = '0;                    o_cout = i_cin;             end
      OP_FILL: begin o_result = {DATA_W{i_value[DATA_W-1]}}; o_cout = i_value[DATA_W-1]; end
      default: begin o_result = i_value;               o_cout = i_cin;             end
    endcase
  end

endmodule

// File: rtl/shifter_operand_pipe.sv
// Two-stage elastic pipeline producing the shifter operand and carry-out.
// Latency 2, full throughput; output holds while out_ready is low, in_ready = !v1 | adv2.
module shifter_operand_pipe
  import shifter_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int TAG_W         = 4,
  parameter bit IMM8_SIGN_EXT = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_src_sel,
  input  logic [7:0]                in_imm8,
  input  logic [3:0]                in_rot,
  input  logic [DATA_W-1:0]         in_imm32,
  input  logic [DATA_W-1:0]         in_rm,
  input  logic [7:0]                in_rs,
  input  logic [1:0]                in_shift_type,
  input  logic [clog2(DATA_W)-1:0]  in_shift_imm,
  input  logic                      in_shift_by_reg,
  input  logic                      in_carry,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_operand,
  output logic                      out_carry,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int AMT_W = clog2(DATA_W);

  logic [DATA_W-1:0] w_imm8_zext, w_imm8_ext, w_rot_val, w_value;
  logic [AMT_W-1:0]  w_rot_amt, w_amt;
  shop_e             w_op;
  logic              w_cseed;
  logic              w_adv2, w_accept;
  logic [DATA_W-1:0] w_result;
  logic              w_cout;

  logic              r_v1, r_v2;
  logic [DATA_W-1:0] r_s1_value;
  shop_e             r_s1_op;
  logic [AMT_W-1:0]  r_s1_amt;
  logic              r_s1_cin;
  logic [TAG_W-1:0]  r_s1_tag;
  logic [DATA_W-1:0] r_out_operand;
  logic              r_out_carry;
  logic [TAG_W-1:0]  r_out_tag;

  assign w_imm8_zext = {{(DATA_W-8){1'b0}}, in_imm8};
  assign w_imm8_ext  = IMM8_SIGN_EXT ? {{(DATA_W-8){in_imm8[7]}}, in_imm8} : w_imm8_zext;
  assign w_rot_amt   = AMT_W'({in_rot, 1'b0});
  assign w_rot_val   = (w_imm8_zext >> w_rot_amt) | (w_imm8_zext << (AMT_W'(0) - w_rot_amt));

  always_comb begin
    case (in_src_sel)
      SRC_EXT_IMM8: w_value = w_imm8_ext;
      SRC_RM:       w_value = in_rm;
      SRC_IMM32:    w_value = in_imm32;
      default:      w_value = w_rot_val;
    endcase
  end

  // Fold every amount edge case into a normalised op plus a pre-computed carry.
  always_comb begin
    w_op    = OP_PASS;
    w_amt   = in_shift_imm;
    w_cseed = in_carry;
    if (in_src_sel == SRC_ROT_IMM8) begin
      w_cseed = (in_rot == 4'd0) ? in_carry : w_rot_val[DATA_W-1];
    end else if (!in_shift_by_reg) begin
      case (in_shift_type)
        SHIFT_LSL: w_op = (in_shift_imm == '0) ? OP_PASS : OP_LSL;
        SHIFT_LSR: begin
          w_op = (in_shift_imm == '0) ? OP_ZERO : OP_LSR;
          if (in_shift_imm == '0) w_cseed = w_value[DATA_W-1];
        end
        SHIFT_ASR: w_op = (in_shift_imm == '0) ? OP_FILL : OP_ASR;
        default:   w_op = (in_shift_imm == '0) ? OP_RRX : OP_ROR;
      endcase
    end else if (in_rs != 8'd0) begin
      w_amt = AMT_W'(in_rs);
      case (in_shift_type)
        SHIFT_LSL: begin
          w_op = (int'(in_rs) < DATA_W) ? OP_LSL : OP_ZERO;
          if (int'(in_rs) >= DATA_W) w_cseed = (int'(in_rs) == DATA_W) ? w_value[0] : 1'b0;
        end
        SHIFT_LSR: begin
          w_op = (int'(in_rs) < DATA_W) ? OP_LSR : OP_ZERO;
          if (int'(in_rs) >= DATA_W) w_cseed = (int'(in_rs) == DATA_W) ? w_value[DATA_W-1] : 1'b0;
        end
        SHIFT_ASR: w_op = (int'(in_rs) < DATA_W) ? OP_ASR : OP_FILL;
        default: begin
          w_op = (w_amt == '0) ? OP_PASS : OP_ROR;
          if (w_amt == '0) w_cseed = w_value[DATA_W-1];
        end
      endcase
    end
  end

  assign w_adv2   = !r_v2 || out_ready;
  assign in_ready = !r_v1 || w_adv2;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (flush) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (in_ready) r_v1 <= in_valid;
      if (w_adv2)   r_v2 <= r_v1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_value <= '0;
      r_s1_op    <= OP_PASS;
      r_s1_amt   <= '0;
      r_s1_cin   <= 1'b0;
      r_s1_tag   <= '0;
    end else if (w_accept) begin
      r_s1_value <= w_value;
      r_s1_op    <= w_op;
      r_s1_amt   <= w_amt;
      r_s1_cin   <= w_cseed;
      r_s1_tag   <= in_tag;
    end
  end

  shift_core #(.DATA_W(DATA_W), .AMT_W(AMT_W)) u_shift_core (
    .i_value  (r_s1_value),
    .i_op     (r_s1_op),
    .i_amt    (r_s1_amt),
    .i_cin    (r_s1_cin),
    .o_result (w_result),
    .o_cout   (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_operand <= '0;
      r_out_carry   <= 1'b0;
      r_out_tag     <= '0;
    end else if (w_adv2 && r_v1) begin
      r_out_operand <= w_result;
      r_out_carry   <= w_cout;
      r_out_tag     <= r_s1_tag;
    end
  end

  assign out_valid   = r_v2;
  assign out_operand = r_out_operand;
  assign out_carry   = r_out_carry;
  assign out_tag     = r_out_tag;

endmodule

// File: tb/tb_shifter_operand_pipe.sv
// Directed bench for shifter_operand_pipe with hand-computed expected values.
module tb_shifter_operand_pipe;

  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready;
  logic [1:0]    in_src_sel, in_shift_type;
  logic [7:0]    in_imm8, in_rs;
  logic [3:0]    in_rot;
  logic [W-1:0]  in_imm32, in_rm;
  logic [4:0]    in_shift_imm;
  logic          in_shift_by_reg, in_carry;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready, out_carry;
  logic [W-1:0]  out_operand;
  logic [TW-1:0] out_tag;

  int       n_vec  = 0;
  int       n_miss = 0;
  logic [3:0] tag_ctr = 4'd0;

  always #5 clk = ~clk;

  shifter_operand_pipe #(.DATA_W(W), .TAG_W(TW), .IMM8_SIGN_EXT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src_sel(in_src_sel), .in_imm8(in_imm8), .in_rot(in_rot),
    .in_imm32(in_imm32), .in_rm(in_rm), .in_rs(in_rs),
    .in_shift_type(in_shift_type), .in_shift_imm(in_shift_imm),
    .in_shift_by_reg(in_shift_by_reg), .in_carry(in_carry), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_operand(out_operand), .out_carry(out_carry), .out_tag(out_tag)
  );

  task automatic check_dat(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] src, input logic [7:0] imm8, input logic [3:0] rot,
                       input logic [31:0] imm32, input logic [31:0] rm, input logic [7:0] rs,
                       input logic [1:0] st, input logic [4:0] simm, input logic byreg,
                       input logic cin, input logic [3:0] tg);
    in_src_sel = src; in_imm8 = imm8; in_rot = rot; in_imm32 = imm32; in_rm = rm;
    in_rs = rs; in_shift_type = st; in_shift_imm = simm; in_shift_by_reg = byreg;
    in_carry = cin; in_tag = tg;
  endtask

  task automatic apply_vec(input string name, input logic [1:0] src, input logic [7:0] imm8,
                           input logic [3:0] rot, input logic [31:0] imm32, input logic [31:0] rm,
                           input logic [7:0] rs, input logic [1:0] st, input logic [4:0] simm,
                           input logic byreg, input logic cin,
                           input logic [31:0] exp_op, input logic exp_c);
    logic [3:0] tg;
    tg = tag_ctr;
    tag_ctr = tag_ctr + 4'd1;
    @(posedge clk); #1;
    drive(src, imm8, rot, imm32, rm, rs, st, simm, byreg, cin, tg);
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_dat({name, "_lat1"}, out_valid, 0);
    @(negedge clk);
    check_dat({name, "_vld"}, out_valid, 1);
    check_dat({name, "_op"}, out_operand, exp_op);
    check_dat({name, "_c"}, out_carry, exp_c);
    check_dat({name, "_tag"}, out_tag, tg);
  endtask

  initial begin
    int sent, rcvd;
    bit seen_low;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(2'b00, 8'h00, 4'h0, 32'h0, 32'h0, 8'h00, 2'b00, 5'd0, 1'b0, 1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check_dat("rst_vld", out_valid, 0);
    check_dat("rst_rdy", in_ready, 1);
    check_dat("rst_op", out_operand, 0);
    check_dat("rst_tag", out_tag, 0);
    @(negedge clk); rst_n = 1'b1;

    //        name      src    imm8  rot  imm32         rm            rs     st     simm byreg cin  exp_op        exp_c
    apply_vec("sext",   2'b00, 8'h80, 4'd0, 32'h0,        32'h0,        8'd0,  2'b00, 5'd0, 1'b0, 1'b1, 32'hFFFFFF80, 1'b1);
    apply_vec("rot8",   2'b11, 8'hFF, 4'd4, 32'h0,        32'h0,        8'd40, 2'b00, 5'd3, 1'b1, 1'b0, 32'hFF000000, 1'b1);
    apply_vec("rot0c1", 2'b11, 8'hFF, 4'd0, 32'h0,        32'h0,        8'd0,  2'b11, 5'd0, 1'b0, 1'b1, 32'h000000FF, 1'b1);
    apply_vec("rot0c0", 2'b11, 8'hFF, 4'd0, 32'h0,        32'h0,        8'd0,  2'b00, 5'd0, 1'b0, 1'b0, 32'h000000FF, 1'b0);
    apply_vec("rot2",   2'b11, 8'h03, 4'd1, 32'h0,        32'h0,        8'd0,  2'b00, 5'd0, 1'b0, 1'b0, 32'hC0000000, 1'b1);
    apply_vec("rlsl32", 2'b01, 8'h00, 4'd0, 32'h0,        32'h80000001, 8'd32, 2'b00, 5'd0, 1'b1, 1'b0, 32'h00000000, 1'b1);
    apply_vec("rlsr33", 2'b01, 8'h00, 4'd0, 32'h0,        32'h80000001, 8'd33, 2'b01, 5'd0, 1'b1, 1'b1, 32'h00000000, 1'b0);
    apply_vec("rlsr32", 2'b01, 8'h00, 4'd0, 32'h0,        32'h80000001, 8'd32, 2'b01, 5'd0, 1'b1, 1'b0, 32'h00000000, 1'b1);
    apply_vec("rasr40", 2'b01, 8'h00, 4'd0, 32'h0,        32'h80000001, 8'd40, 2'b10, 5'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1);
    apply_vec("rror64", 2'b01, 8'h00, 4'd0, 32'h0,        32'h80000001, 8'd64, 2'b11, 5'd0, 1'b1, 1'b0, 32'h80000001, 1'b1);
    apply_vec("rrx",    2'b01, 8'h00, 4'd0, 32'h0,        32'h00000003, 8'd0,  2'b11, 5'd0, 1'b0, 1'b1, 32'h80000001, 1'b1);
    apply_vec("ilsr0",  2'b01, 8'h00, 4'd0, 32'h0,        32'h00000003, 8'd0,  2'b01, 5'd0, 1'b0, 1'b1, 32'h00000000, 1'b0);
    apply_vec("ilsl4",  2'b01, 8'h00, 4'd0, 32'h0,        32'hF000000F, 8'd0,  2'b00, 5'd4, 1'b0, 1'b0, 32'h000000F0, 1'b1);
    apply_vec("iasr4",  2'b01, 8'h00, 4'd0, 32'h0,        32'h80000010, 8'd0,  2'b10, 5'd4, 1'b0, 1'b1, 32'hF8000001, 1'b0);
    apply_vec("iasr0",  2'b01, 8'h00, 4'd0, 32'h0,        32'h7FFFFFFF, 8'd0,  2'b10, 5'd0, 1'b0, 1'b1, 32'h00000000, 1'b0);
    apply_vec("rror36", 2'b01, 8'h00, 4'd0, 32'h0,        32'h0000001F, 8'd36, 2'b11, 5'd0, 1'b1, 1'b0, 32'hF0000001, 1'b1);
    apply_vec("i32lsr", 2'b10, 8'h00, 4'd0, 32'h12345678, 32'h0,        8'd0,  2'b01, 5'd4, 1'b0, 1'b0, 32'h01234567, 1'b1);
    apply_vec("zlsr1",  2'b00, 8'h7F, 4'd0, 32'h0,        32'h0,        8'd0,  2'b01, 5'd1, 1'b0, 1'b0, 32'h0000003F, 1'b1);
    apply_vec("rlsl33", 2'b01, 8'h00, 4'd0, 32'h0,        32'h00000001, 8'd33, 2'b00, 5'd0, 1'b1, 1'b1, 32'h00000000, 1'b0);
    apply_vec("rlsl31", 2'b01, 8'h00, 4'd0, 32'h0,        32'h00000003, 8'd31, 2'b00, 5'd0, 1'b1, 1'b0, 32'h80000000, 1'b1);
    apply_vec("rlsr1",  2'b01, 8'h00, 4'd0, 32'h0,        32'h00000003, 8'd1,  2'b01, 5'd0, 1'b1, 1'b0, 32'h00000001, 1'b1);
    apply_vec("rzero",  2'b01, 8'h00, 4'd0, 32'h0,        32'h00000055, 8'd0,  2'b01, 5'd7, 1'b1, 1'b1, 32'h00000055, 1'b1);

    // Stream of 8 tags with the consumer stalled for the first 3 cycles.
    @(posedge clk);
    sent = 0; rcvd = 0; seen_low = 1'b0;
    for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 3);
      in_valid  = (sent < 8);
      drive(2'b01, 8'h00, 4'd0, 32'h0, sent * 32'h11111111, 8'd0, 2'b00, 5'd1, 1'b0, 1'b0, 4'(sent));
      @(negedge clk);
      if (!in_ready && !seen_low) begin
        seen_low = 1'b1;
        check_dat("str_acc_at_stall", sent, 2);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        check_dat("str_tag", out_tag, rcvd[3:0]);
        if (out_ready) begin
          check_dat("str_op", out_operand, (rcvd * 32'h11111111) << 1);
          check_dat("str_c", out_carry, 0);
          rcvd++;
        end
      end
    end
    in_valid = 1'b0;
    check_dat("str_count", rcvd, 8);
    check_dat("str_stalled", seen_low, 1);

    // Flush with both stages full and a request pending.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(2'b01, 8'h00, 4'd0, 32'h0, 32'h0000AAAA, 8'd0, 2'b00, 5'd0, 1'b0, 1'b0, 4'hA);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_tag = 4'hB;
    @(posedge clk); #1;
    in_tag = 4'hC; flush = 1'b1;
    @(negedge clk);
    check_dat("fl_pre_vld", out_valid, 1);
    check_dat("fl_pre_tag", out_tag, 4'hA);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_dat("fl_out_vld", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_dat("fl_drain_vld", out_valid, 0);
    end

    // Flush on an empty pipe drops the request accepted in the same cycle.
    @(posedge clk); #1;
    in_tag = 4'hD; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check_dat("fl2_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_dat("fl2_vld", out_valid, 0);
    end

    // Reset in the middle of a stalled stream.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(2'b01, 8'h00, 4'd0, 32'h0, 32'hFFFFFFFF, 8'd0, 2'b00, 5'd0, 1'b0, 1'b1, 4'h5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_tag = 4'h6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_dat("rst2_pre_tag", out_tag, 4'h5);
    check_dat("rst2_pre_c", out_carry, 1);
    #2 rst_n = 1'b0;
    #1;
    check_dat("rst2_vld", out_valid, 0);
    check_dat("rst2_op", out_operand, 0);
    check_dat("rst2_c", out_carry, 0);
    check_dat("rst2_tag", out_tag, 0);
    check_dat("rst2_rdy", in_ready, 1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_dat("rst2_after_vld", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
